// File: rtl/fountain_pkg.sv
// Shared types and defaults for the GF(2) fountain-code decoder.
// The row struct documents the pivot-store row layout for the default geometry.
package fountain_pkg;

  localparam int K_DEF = 8;
  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REDUCE  = 3'd1,
    INSERT  = 3'd2,
    BACKSUB = 3'd3,
    DRAIN   = 3'd4
  } fd_state_t;

  typedef struct packed {
    logic [K_DEF-1:0] mask;
    logic [W_DEF-1:0] data;
  } fd_row_t;

endpackage

// File: rtl/fountain_pivot_store.sv
// Upper-triangular pivot store: K rows of {mask, data} with per-row pivot flags.
// Combinational read of row rd_idx, a flat view of all row data, one write port.
module fountain_pivot_store #(
  parameter int K = 8,
  parameter int W = 8,
  localparam int IW = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [IW-1:0]  rd_idx,
  output logic [K-1:0]   rd_mask,
  output logic [W-1:0]   rd_data,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [K-1:0]   wr_mask,
  input  logic [W-1:0]   wr_data,
  output logic [K*W-1:0] all_data,
  output logic [K-1:0]   pivot_valid
);

  logic [K-1:0] mask_mem [K];
  logic [W-1:0] data_mem [K];
  logic [K-1:0] valid_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mask_mem[wr_idx] <= wr_mask;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Clearing the flags is enough to empty the store; row contents are don't-care.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  assign rd_mask     = mask_mem[rd_idx];
  assign rd_data     = data_mem[rd_idx];
  assign pivot_valid = valid_reg;

  genvar gi;
  for (gi = 0; gi < K; gi++) begin : g_view
    assign all_data[gi*W +: W] = data_mem[gi];
  end

endmodule

// File: rtl/fountain_decoder.sv
// GF(2) fountain-code decoder: incremental elimination into a pivot store,
// back-substitution at full rank, then a valid/ready drain of the K source words.
module fountain_decoder
  import fountain_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         in_mask,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(K)-1:0] out_index,
  output logic [W-1:0]         out_data,
  output logic [$clog2(K):0]   rank,
  output logic [7:0]           dropped,
  output logic                 done
);

  localparam int IW = $clog2(K);

  fd_state_t     state_reg;
  logic [IW-1:0] cnt_reg;
  logic [K-1:0]  work_mask_reg;
  logic [W-1:0]  work_data_reg;
  logic [IW:0]   rank_reg;
  logic [7:0]    dropped_reg;
  logic          done_reg;

  logic [K-1:0]   rd_mask;
  logic [W-1:0]   rd_data;
  logic [K*W-1:0] all_data;
  logic [K-1:0]   pivot_valid;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [K-1:0]   wr_mask;
  logic [W-1:0]   wr_data;
  logic           clr;
  logic [W-1:0]   bs_data;

  function automatic logic [IW-1:0] msb_index(input logic [K-1:0] m);
    msb_index = '0;
    for (int b = 0; b < K; b++) begin
      if (m[b]) msb_index = IW'(b);
    end
  endfunction

  fountain_pivot_store #(.K(K), .W(W)) u_store (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .rd_idx      (cnt_reg),
    .rd_mask     (rd_mask),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_mask     (wr_mask),
    .wr_data     (wr_data),
    .all_data    (all_data),
    .pivot_valid (pivot_valid)
  );

  // Rows below cnt_reg are already unit rows, so their data is final.
  always_comb begin
    bs_data = rd_data;
    for (int j = 0; j < K; j++) begin
      if (j < int'(cnt_reg) && rd_mask[j]) bs_data = bs_data ^ all_data[j*W +: W];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cnt_reg;
    wr_mask = work_mask_reg;
    wr_data = work_data_reg;
    case (state_reg)
      INSERT: begin
        wr_en  = |work_mask_reg;
        wr_idx = msb_index(work_mask_reg);
      end
      BACKSUB: begin
        wr_en   = 1'b1;
        wr_mask = {{(K-1){1'b0}}, 1'b1} << cnt_reg;
        wr_data = bs_data;
      end
      default: ;
    endcase
  end

  assign clr = (state_reg == DRAIN) && out_ready && (cnt_reg == IW'(K-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      work_mask_reg <= '0;
      work_data_reg <= '0;
      rank_reg      <= '0;
      dropped_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_mask_reg <= in_mask;
            work_data_reg <= in_data;
            cnt_reg       <= IW'(K-1);
            state_reg     <= REDUCE;
          end
        end
        REDUCE: begin
          if (work_mask_reg[cnt_reg] && pivot_valid[cnt_reg]) begin
            work_mask_reg <= work_mask_reg ^ rd_mask;
            work_data_reg <= work_data_reg ^ rd_data;
          end
          if (cnt_reg == '0) state_reg <= INSERT;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        INSERT: begin
          if (work_mask_reg == '0) begin
            if (dropped_reg != 8'hFF) dropped_reg <= dropped_reg + 1'b1;
            state_reg <= IDLE;
          end else begin
            rank_reg <= rank_reg + 1'b1;
            if (rank_reg == (IW+1)'(K-1)) begin
              cnt_reg   <= '0;
              state_reg <= BACKSUB;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        BACKSUB: begin
          if (cnt_reg == IW'(K-1)) begin
            cnt_reg   <= '0;
            state_reg <= DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (cnt_reg == IW'(K-1)) begin
              done_reg  <= 1'b1;
              rank_reg  <= '0;
              cnt_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DRAIN);
  assign out_index = out_valid ? cnt_reg : '0;
  assign out_data  = out_valid ? rd_data : '0;
  assign rank      = rank_reg;
  assign dropped   = dropped_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_fountain_decoder.sv
// Scoreboard bench: a span-set model of the received equations predicts rank,
// drops and the recovered words; a negedge monitor checks every output beat.
module tb_fountain_decoder;
  import fountain_pkg::*;

  localparam int K = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [K-1:0] in_mask = '0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2:0]   out_index;
  logic [W-1:0] out_data;
  logic [3:0]   rank;
  logic [7:0]   dropped;
  logic         done;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic [W-1:0] src [K];
  bit    span [256];
  int    m_rank = 0;
  int    m_dropped = 0;
  bit    m_complete = 0;
  bit    done_pending = 0;
  bit    rand_ready = 0;
  bit    stall_arm = 0;
  int    stall_cnt = 0;
  bit    mon_en = 0;

  always #5 clk = ~clk;

  fountain_decoder #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .rank      (rank),
    .dropped   (dropped),
    .done      (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // The set of all masks reachable from received symbols; its size is 2^rank.
  function automatic void model_reset();
    foreach (span[v]) span[v] = 0;
    span[0] = 1;
    m_rank = 0;
    m_complete = 0;
  endfunction

  function automatic void model_symbol(input logic [K-1:0] m);
    bit nxt [256];
    if (span[m]) begin
      if (m_dropped < 255) m_dropped++;
    end else begin
      nxt = span;
      foreach (span[v]) if (span[v]) nxt[v ^ int'(m)] = 1;
      span = nxt;
      m_rank++;
      if (m_rank == K) begin
        m_complete = 1;
        for (int i = 0; i < K; i++) exp_q.push_back('{idx: i, data: src[i]});
      end
    end
  endfunction

  function automatic logic [W-1:0] enc(input logic [K-1:0] m);
    enc = '0;
    for (int i = 0; i < K; i++) if (m[i]) enc = enc ^ src[i];
  endfunction

  task automatic send(input logic [K-1:0] m, input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_mask  = m;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_symbol(m);
    $display("symbol mask=%h data=%h model_rank=%0d model_dropped=%0d", m, d, m_rank, m_dropped);
  endtask

  task automatic send_src(input logic [K-1:0] m);
    send(m, enc(m));
  endtask

  task automatic check_insert();
    repeat (K + 1) @(posedge clk);
    @(negedge clk);
    chk("rank", int'(rank), m_rank);
    chk("dropped", int'(dropped), m_dropped);
    chk("in_ready_after_insert", int'(in_ready), m_complete ? 0 : 1);
    if (m_complete) model_reset();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("rank_after_done", int'(rank), 0);
  endtask

  function automatic void randomize_src();
    for (int i = 0; i < K; i++) src[i] = W'($urandom_range(0, 255));
  endfunction

  // Peeking the queue head every cycle also proves the beat is held under backpressure.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      done_pending = 0;
    end else if (mon_en) begin
      chk("done", int'(done), done_pending ? 1 : 0);
      done_pending = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("out_index", int'(out_index), exp_q[0].idx);
          chk("out_data", int'(out_data), int'(exp_q[0].data));
          if (out_ready) begin
            b = exp_q.pop_front();
            $display("beat index=%0d data=%h", out_index, out_data);
            if (b.idx == K - 1) done_pending = 1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_arm && out_valid && out_index == 3'd4 && stall_cnt < 3) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int blocks;
    bit was_complete;
    model_reset();
    m_dropped = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_index", int'(out_index), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_rank", int'(rank), 0);
    chk("reset_dropped", int'(dropped), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    mon_en = 1;
    #1 chk("in_ready_after_reset", int'(in_ready), 1);

    // Identity block
    for (int i = 0; i < K; i++) src[i] = W'(8'h10 + i);
    for (int i = 0; i < K; i++) begin
      send_src(K'(1 << i));
      check_insert();
    end
    wait_drain();
    chk("identity_dropped", int'(dropped), 0);

    // Mixed combination followed by identity symbols
    randomize_src();
    src[0] = 8'hA5;
    src[1] = 8'h3C;
    send(8'h03, 8'h99);
    check_insert();
    send(8'h01, 8'hA5);
    check_insert();
    for (int i = 2; i < K; i++) begin
      send_src(K'(1 << i));
      check_insert();
    end
    wait_drain();

    // Redundant and zero-mask symbols, then a block drained with backpressure at index 4
    randomize_src();
    send_src(8'h01);
    check_insert();
    send_src(8'h01);
    check_insert();
    send(8'h00, 8'hFF);
    check_insert();
    stall_arm = 1;
    stall_cnt = 0;
    for (int i = 1; i < K; i++) begin
      send_src(K'(1 << i));
      check_insert();
    end
    wait_drain();
    chk("stall_cycles", stall_cnt, 3);
    stall_arm = 0;

    // Reset in the middle of REDUCE with five pivots held
    randomize_src();
    for (int i = 0; i < 5; i++) begin
      send_src(K'(1 << i));
      check_insert();
    end
    send_src(8'h20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_in_ready_low", int'(in_ready), 0);
    chk("midreset_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    model_reset();
    m_dropped = 0;
    exp_q.delete();
    #1;
    chk("midreset_in_ready", int'(in_ready), 1);
    chk("midreset_rank", int'(rank), 0);
    chk("midreset_dropped", int'(dropped), 0);
    randomize_src();
    for (int i = 0; i < K; i++) begin
      send_src(K'(1 << i));
      check_insert();
    end
    wait_drain();

    // Random masks (including zero and dependent ones) with random sink readiness
    rand_ready = 1;
    blocks = 0;
    randomize_src();
    for (int n = 0; n < 400 && blocks < 4; n++) begin
      send_src(K'($urandom_range(0, 255)));
      was_complete = m_complete;
      check_insert();
      if (was_complete) begin
        wait_drain();
        blocks++;
        randomize_src();
      end
    end
    chk("random_blocks", blocks, 4);
    rand_ready = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
